// File: rtl/mask_match_scheduler_if.sv
// Block/beat handshake bundle for mask_match_scheduler.
// Optional counters are present only when MASK_MATCH_STATS_EN is defined.
interface mask_match_scheduler_if #(
    parameter int BITMASK_LENGTH = 16,
    parameter int INDEX_BITWIDTH = 5,
    parameter int LANES          = 2
);
    logic                              ivalid;
    logic                              oready;
    logic [BITMASK_LENGTH-1:0]         bitmaskW;
    logic [BITMASK_LENGTH-1:0]         bitmaskA;
    logic                              ovalid;
    logic                              iready;
    logic [LANES-1:0]                  laneValid;
    logic [LANES*INDEX_BITWIDTH-1:0]   laneIndexW;
    logic [LANES*INDEX_BITWIDTH-1:0]   laneIndexA;
    logic [INDEX_BITWIDTH-1:0]         numW;
    logic [INDEX_BITWIDTH-1:0]         numA;
    logic                              last;
`ifdef MASK_MATCH_STATS_EN
    logic [31:0]                       blockCount;
    logic [31:0]                       pairCount;
`endif

    modport master (
        output ivalid, bitmaskW, bitmaskA, iready,
        input  oready, ovalid, laneValid, laneIndexW, laneIndexA, numW, numA, last
`ifdef MASK_MATCH_STATS_EN
        , input blockCount, pairCount
`endif
    );

    modport slave (
        input  ivalid, bitmaskW, bitmaskA, iready,
        output oready, ovalid, laneValid, laneIndexW, laneIndexA, numW, numA, last
`ifdef MASK_MATCH_STATS_EN
        , output blockCount, pairCount
`endif
    );
endinterface

// File: rtl/mask_match_scheduler.sv
// Walks the mutual set bits of a W/A bitmask pair, issuing up to LANES packed-index pairs per beat.
// Optional block/pair counters are enabled by defining MASK_MATCH_STATS_EN.
module mask_match_scheduler #(
    parameter int BITMASK_LENGTH = 16,
    parameter int INDEX_BITWIDTH = 5,
    parameter int LANES          = 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    mask_match_scheduler_if.slave bus
);
    localparam int BL = BITMASK_LENGTH;
    localparam int IW = INDEX_BITWIDTH;
    localparam int NL = LANES;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          r_state;
    logic [BL-1:0]   r_mask_w;
    logic [BL-1:0]   r_mask_a;
    logic [BL-1:0]   r_remain;
    logic [IW-1:0]   r_num_w;
    logic [IW-1:0]   r_num_a;

    logic            w_accept;
    logic            w_retire;
    logic            w_last;
    logic            w_oready;
    logic [BL-1:0]   w_issued;
    logic [NL-1:0]   w_lane_valid;
    logic [IW-1:0]   w_lane_idx_w [NL];
    logic [IW-1:0]   w_lane_idx_a [NL];
    logic [IW-1:0]   w_pop_w_in;
    logic [IW-1:0]   w_pop_a_in;

    // Lane k takes the k-th lowest remaining bit; its indices are the set-bit counts below it.
    always_comb begin : beat_select
        logic [IW-1:0] cnt_r;
        logic [IW-1:0] cnt_w;
        logic [IW-1:0] cnt_a;
        cnt_r        = '0;
        cnt_w        = '0;
        cnt_a        = '0;
        w_issued     = '0;
        w_lane_valid = '0;
        for (int k = 0; k < NL; k++) begin
            w_lane_idx_w[k] = '0;
            w_lane_idx_a[k] = '0;
        end
        for (int p = 0; p < BL; p++) begin
            for (int k = 0; k < NL; k++) begin
                if (r_remain[p] && (cnt_r == IW'(k))) begin
                    w_lane_valid[k] = 1'b1;
                    w_lane_idx_w[k] = cnt_w;
                    w_lane_idx_a[k] = cnt_a;
                    w_issued[p]     = 1'b1;
                end
            end
            if (r_remain[p]) begin
                cnt_r = cnt_r + IW'(1);
            end
            cnt_w = cnt_w + IW'(r_mask_w[p]);
            cnt_a = cnt_a + IW'(r_mask_a[p]);
        end
    end

    always_comb begin : input_popcount
        w_pop_w_in = '0;
        w_pop_a_in = '0;
        for (int p = 0; p < BL; p++) begin
            w_pop_w_in = w_pop_w_in + IW'(bus.bitmaskW[p]);
            w_pop_a_in = w_pop_a_in + IW'(bus.bitmaskA[p]);
        end
    end

    assign w_last   = (r_state == ISSUE) && ((r_remain & ~w_issued) == '0);
    assign w_retire = (r_state == ISSUE) && bus.iready;
    // A new block may enter on the very edge that retires the final beat.
    assign w_oready = resetn && ((r_state == IDLE) || (w_retire && w_last));
    assign w_accept = bus.ivalid && w_oready;

`ifdef MASK_MATCH_STATS_EN
    logic [31:0] r_block_cnt;
    logic [31:0] r_pair_cnt;
    logic [31:0] w_pair_inc;

    always_comb begin
        w_pair_inc = '0;
        for (int k = 0; k < NL; k++) begin
            w_pair_inc = w_pair_inc + 32'(w_lane_valid[k]);
        end
    end
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_mask_w    <= '0;
            r_mask_a    <= '0;
            r_remain    <= '0;
            r_num_w     <= '0;
            r_num_a     <= '0;
`ifdef MASK_MATCH_STATS_EN
            r_block_cnt <= '0;
            r_pair_cnt  <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_state  <= ISSUE;
                r_mask_w <= bus.bitmaskW;
                r_mask_a <= bus.bitmaskA;
                r_remain <= bus.bitmaskW & bus.bitmaskA;
                r_num_w  <= w_pop_w_in;
                r_num_a  <= w_pop_a_in;
            end else if (w_retire) begin
                if (w_last) begin
                    r_state  <= IDLE;
                    r_remain <= '0;
                end else begin
                    r_remain <= r_remain & ~w_issued;
                end
            end
`ifdef MASK_MATCH_STATS_EN
            if (w_retire) begin
                r_pair_cnt <= r_pair_cnt + w_pair_inc;
                if (w_last) begin
                    r_block_cnt <= r_block_cnt + 32'd1;
                end
            end
`endif
        end
    end

    assign bus.oready    = w_oready;
    assign bus.ovalid    = (r_state == ISSUE);
    assign bus.last      = w_last;
    assign bus.laneValid = w_lane_valid;
    assign bus.numW      = r_num_w;
    assign bus.numA      = r_num_a;

    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_lane_pack
            assign bus.laneIndexW[gi*IW +: IW] = w_lane_idx_w[gi];
            assign bus.laneIndexA[gi*IW +: IW] = w_lane_idx_a[gi];
        end
    endgenerate

`ifdef MASK_MATCH_STATS_EN
    assign bus.blockCount = r_block_cnt;
    assign bus.pairCount  = r_pair_cnt;
`endif
endmodule

// File: doc/mask_match_scheduler.md
Name: mask_match_scheduler

Overview:
- Sequences sparse operand matching for one PE.
- Accepts a pair of 16-lane sparsity bitmasks (weight W, activation A) per block and walks their mutual set bits.
- Each cycle it issues up to LANES matched pairs of packed-buffer indices, so the PE can fetch the dense W and A operands that multiply together.
- Also reports per-block dense operand counts, so the operand buffers can advance their read pointers.

Parameters:
BITMASK_LENGTH, 16, number of bits per bitmask
INDEX_BITWIDTH, 5, width of each packed index and of each count field; must satisfy 2^INDEX_BITWIDTH > BITMASK_LENGTH
LANES, 2, maximum matched pairs issued per output beat

Ports:
clock  in  1  single clock
resetn  in  1  reset; asynchronous, active-low
ivalid  in  1  upstream block valid
oready  out  1  ready to accept a block from upstream
bitmaskW  in  BITMASK_LENGTH  weight sparsity mask, LSB = element 0
bitmaskA  in  BITMASK_LENGTH  activation sparsity mask, LSB = element 0
ovalid  out  1  output beat valid
iready  in  1  downstream accepts beat
laneValid  out  LANES  per-lane pair valid, packed from lane 0 upward
laneIndexW  out  LANES*INDEX_BITWIDTH  per-lane index into the packed W buffer
laneIndexA  out  LANES*INDEX_BITWIDTH  per-lane index into the packed A buffer
numW  out  INDEX_BITWIDTH  popcount(bitmaskW) of the current block
numA  out  INDEX_BITWIDTH  popcount(bitmaskA) of the current block
last  out  1  final beat of the current block

Behaviour:
- Reset (resetn low, async):
  - state = IDLE; ovalid = 0; last = 0; laneValid = 0.
  - Index and count outputs = 0; internal mask registers = 0.
  - oready = 0 while resetn is low.
- States: IDLE and ISSUE.
- Block acceptance: a block is accepted on a rising edge where ivalid && oready.
  - Registers bitmaskW and bitmaskA.
  - Sets remaining mask R = bitmaskW & bitmaskA.
  - Moves to ISSUE.
- oready:
  - 1 in IDLE.
  - In ISSUE, oready = ovalid && iready && last. This is the back-to-back path: a new block is accepted in the same cycle the final beat retires, with no bubble.
- Latency: first beat ovalid = 1 in the cycle after acceptance.
- ovalid = 1 throughout ISSUE.
- Beat contents: lane k carries the k-th lowest set bit p of R, for k < LANES.
  - laneIndexW[k] = number of set bits of latched W strictly below position p.
  - laneIndexA[k] = same count using latched A.
  - laneValid[k] = 1 if that bit exists; otherwise 0, and the lane's indices are 0.
- last = 1 when popcount(R) <= LANES.
- numW and numA hold constant for every beat of the block.
- Backpressure: while ovalid && !iready, all outputs and R hold stable.
- Beat retire: when ovalid && iready:
  - Clear the issued bits from R.
  - If last: go to IDLE, or stay in ISSUE if a new block is accepted in the same cycle.
- Empty mutual mask (R = 0 at acceptance): exactly one beat with laneValid = 0 and last = 1; numW and numA still valid.
- Beat count per block = max(1, ceil(popcount(W&A)/LANES)).
- Full masks (W = A = all ones): indices run 0..BITMASK_LENGTH-1 in order.
- Count width: numW and numA reach BITMASK_LENGTH, which fits INDEX_BITWIDTH by the parameter constraint.
- Outputs are functions of registered state only; there is no combinational path from bitmaskW or bitmaskA to any output.
- resetn asserted mid-block: the block is abandoned immediately and no further beats are issued.

Optional Feature:
MASK_MATCH_STATS_EN
- Defined: adds outputs blockCount (32-bit) and pairCount (32-bit).
  - blockCount increments on each retired last beat.
  - pairCount adds popcount(laneValid) on each retired beat.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: both ports and all counter logic are absent; all other behaviour is identical.

Test Plan:
- Basic match (LANES=2): W=16'h00B6, A=16'h00D3 -> 2 beats.
  - Beat 0: laneValid=2'b11, (W,A)=(0,1),(2,2), last=0.
  - Beat 1: laneValid=2'b01, (4,4), last=1.
  - numW=5, numA=5 on both beats.
- Full masks: W=A=16'hFFFF -> 8 beats.
  - Beat k pairs are (2k,2k),(2k+1,2k+1), laneValid=2'b11.
  - last only on beat 7; numW=numA=16.
- Disjoint masks: W=16'h00F0, A=16'h000F -> 1 beat: laneValid=0, last=1, numW=4, numA=4.
- Backpressure: basic match with iready held 0 for 3 cycles at beat 0 -> beat 0 outputs stable for all 3 cycles, oready=0; sequence resumes unchanged after iready=1.
- Back-to-back: second block valid while block 1's last beat retires -> oready=1 in that cycle; block 2 beat 0 appears the next cycle with no bubble.
- Reset mid-block: resetn pulsed low during beat 0 of the full-mask block -> ovalid=0 immediately; after release oready=1 and no stale beats appear. With MASK_MATCH_STATS_EN, counters read 0.
